mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Upstream feeder of the int18-to-bf16 normaliser.
- Accepts a stream of signed int8 operand pairs over a valid/ready handshake and multiplies each pair.
- Accumulates the products into a signed 18-bit dot-product result, one vector per result; the last beat is marked by in_last.
- Presents the final accumulator, a saturation flag and a beat count through a registered valid/ready output that the converter consumes.

Parameters:
- IN_W, 8, signed operand width.
- ACC_W, 18, signed accumulator width; must match the converter input width.
- CNT_W, 5, beat-counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  IN_W  signed operand A.
- in_b  input  IN_W  signed operand B.
- in_last  input  1  final beat of the current vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  signed accumulated result.
- out_sat  output  1  sticky: saturation occurred in this vector.
- out_cnt  output  CNT_W  number of beats accumulated in this vector.

Behaviour:
- Reset (rst_n low at a clock edge) clears everything:
  - out_valid=0, acc_out=0, out_sat=0, out_cnt=0.
  - Product stage empty; in_ready=1 in the following cycle.
  - Reset mid-vector discards the partial sum.
- Two pipeline stages:
  - S1 registers the product p_q=in_a*in_b (2*IN_W bits, signed), plus p_valid and p_last.
  - S2 adds sign-extended p_q into acc.
- Beat acceptance:
  - A beat is accepted on an edge where in_valid && in_ready.
  - in_ready = !out_valid && !(p_valid && p_last), decoded from registers only; no combinational path from in_valid or out_ready.
  - While in_ready is low, in_valid/data are ignored; the source must hold them.
- Latency: for a last beat accepted at edge E, acc_out/out_sat/out_cnt are final and out_valid=1 after edge E+1.
- State machine (2 states, S1 pipeline separate):
  - ACCUM: adds each valid p_q. When p_last is added, goes to HOLD and sets out_valid.
  - HOLD: acc_out, out_sat, out_cnt held stable while out_valid && !out_ready.
  - HOLD exit: on the edge where out_valid && out_ready, clears out_valid, acc, out_sat and out_cnt to 0 and returns to ACCUM. The next vector starts fresh.
  - No input beat is accepted on that same edge (in_ready was 0).
- Arithmetic:
  - The sum is formed in ACC_W+1 bits, then clamped per add to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-131072, 131071].
  - Any clamp sets out_sat until the output handshake.
  - Clamping is per add; later adds continue from the clamped value.
- A vector of one beat (in_last on the first beat) gives acc_out = that product.
- out_cnt increments per S2 add and saturates at 2^CNT_W-1 (no wrap).
- acc_out is driven directly from the acc register and reads the running partial sum while not valid. Consumers use it only when out_valid=1.

Optional Feature:
- Macro: MAC_ACC_SAT_EN.
- Defined: saturating adds and sticky out_sat, as above.
- Undefined: adds wrap modulo 2^ACC_W (two's complement); out_sat is tied 0; the clamp logic is removed.

Decomposition:
- Shared package tpu_pkg holds:
  - ACC_W and IN_W constants.
  - ACC_MAX/ACC_MIN constants.
  - State enum {ACCUM, HOLD}.
- One natural sub-module: sat_add, a combinational ACC_W signed adder with clamp and overflow flag. It honours MAC_ACC_SAT_EN.

Test Plan:
- Reset: hold rst_n=0 two cycles, release -> out_valid=0, acc_out=0, out_sat=0, out_cnt=0, in_ready=1.
- Basic vector: beats (3,4),(-2,5),(7,7),(-128,1,last), continuous valid, out_ready=1 -> acc_out=-77 (18'h3FFB3), out_cnt=4, out_sat=0, out_valid high one edge after the last accept and for exactly one cycle.
- Overflow, 8 beats of (-128,-128):
  - With MAC_ACC_SAT_EN: acc_out=131071 (18'h1FFFF), out_sat=1.
  - Without: acc_out=-131072 (18'h20000), out_sat=0.
  - Also 9 beats of (-128,127) with macro: acc_out=-131072, out_sat=1.
- Backpressure: after a vector completes, hold out_ready=0 for 5 cycles with in_valid=1 and new data:
  - Outputs stay stable and in_ready=0.
  - Then out_ready=1 for one cycle -> handshake.
  - The next vector (127,127,last) gives acc_out=16129, out_cnt=1.
- Reset mid-operation: accept (10,10),(10,10), assert rst_n=0 one cycle, then send (1,1,last) -> acc_out=1, out_cnt=1.
- Gapped input: beats (5,5),(6,6,last) with in_valid low 3 cycles between -> acc_out=61, out_cnt=2.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and state type for the MAC accumulator slice.
`timescale 1ns/1ps
package tpu_pkg;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned ACC_W = 18;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/mac_accumulator_sat_add.sv
// Combinational signed adder; clamps with overflow flag when MAC_ACC_SAT_EN
// is defined, otherwise wraps modulo 2^W with ovf_o tied low.
`timescale 1ns/1ps
module sat_add #(
  parameter int unsigned W = tpu_pkg::ACC_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);
`ifdef MAC_ACC_SAT_EN
  logic [W:0] wide;

  assign wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // Overflow exactly when the two top bits of the widened sum disagree.
  always_comb begin
    sum_o = wide[W-1:0];
    ovf_o = 1'b0;
    if (wide[W] != wide[W-1]) begin
      ovf_o = 1'b1;
      sum_o = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum_o = a_i + b_i;
  assign ovf_o = 1'b0;
`endif
endmodule

// File: rtl/mac_accumulator.sv
// Int8 multiply-accumulate into an 18-bit dot product with valid/ready I/O.
// Saturating adds and sticky out_sat are enabled by MAC_ACC_SAT_EN.
`timescale 1ns/1ps
module mac_accumulator #(
  parameter int unsigned IN_W  = tpu_pkg::IN_W,
  parameter int unsigned ACC_W = tpu_pkg::ACC_W,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_cnt
);
  import tpu_pkg::*;

  localparam int unsigned P_W = 2 * IN_W;

  logic             accept;
  logic [P_W-1:0]   a_ext, b_ext, p_d, p_q;
  logic             p_valid_q, p_last_q;
  logic [ACC_W-1:0] p_ext, sum;
  logic             ovf;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stall only when a result is pending or a last product is about to land.
  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid && !(p_valid_q && p_last_q);
  assign accept    = in_valid && in_ready;

  assign a_ext = {{IN_W{in_a[IN_W-1]}}, in_a};
  assign b_ext = {{IN_W{in_b[IN_W-1]}}, in_b};
  assign p_d   = a_ext * b_ext;
  assign p_ext = {{(ACC_W-P_W){p_q[P_W-1]}}, p_q};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (p_ext),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCUM: begin
        if (p_valid_q) begin
          acc_d = sum;
          sat_d = sat_q | ovf;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (p_last_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      state_q   <= ACCUM;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      p_valid_q <= accept;
      p_last_q  <= accept && in_last;
      if (accept) p_q <= p_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign acc_out = acc_q;
  assign out_sat = sat_q;
  assign out_cnt = cnt_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (either MAC_ACC_SAT_EN build).
`timescale 1ns/1ps
module tb_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, out_sat;
  logic [17:0] acc_out;
  logic [4:0]  out_cnt;

  int passed = 0;
  int total  = 0;

`ifdef MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  mac_accumulator #(.IN_W(8), .ACC_W(18), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_sat   (out_sat),
    .out_cnt   (out_cnt)
  );

  function automatic logic [31:0] a18(input int v);
    return 32'(v) & 32'h3FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    in_last = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic take(input string tag, input int acc, input int cnt, input logic sat);
    wait_out();
    chk({tag, "_acc"}, acc_out, a18(acc));
    chk({tag, "_cnt"}, out_cnt, 32'(cnt));
    chk({tag, "_sat"}, out_sat, 32'(sat));
    out_ready = 1'b1;
    step();
    chk({tag, "_clr"}, out_valid, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_acc",   acc_out,   32'd0);
    chk("rst_sat",   out_sat,   32'd0);
    chk("rst_cnt",   out_cnt,   32'd0);
    chk("rst_ready", in_ready,  32'd1);

    // Basic vector with exact latency and one-cycle valid.
    beat(3, 4, 1'b0);
    beat(-2, 5, 1'b0);
    beat(7, 7, 1'b0);
    beat(-128, 1, 1'b1);
    chk("basic_not_early", out_valid, 32'd0);
    step();
    chk("basic_valid", out_valid, 32'd1);
    chk("basic_acc",   acc_out,   32'h3FFB3);
    chk("basic_cnt",   out_cnt,   32'd4);
    chk("basic_sat",   out_sat,   32'd0);
    step();
    chk("basic_one_cycle", out_valid, 32'd0);
    chk("basic_clear_acc", acc_out,   32'd0);

    // 8 x 16384 = 131072 overflows by one.
    for (int i = 0; i < 8; i++) beat(-128, -128, i == 7);
    take("ovf8", SAT ? 131071 : -131072, 8, SAT);

    // Negative overflow, completed under backpressure with new data waiting.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) beat(-128, 127, i == 8);
    in_valid = 1'b1; in_a = 8'd127; in_b = 8'd127; in_last = 1'b1;
    wait_out();
    chk("neg_acc", acc_out, a18(SAT ? -131072 : 115840));
    chk("neg_cnt", out_cnt, 32'd9);
    chk("neg_sat", out_sat, 32'(SAT));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 32'd1);
      chk("bp_acc",   acc_out,   a18(SAT ? -131072 : 115840));
      chk("bp_cnt",   out_cnt,   32'd9);
      chk("bp_ready", in_ready,  32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_handshake", out_valid, 32'd0);
    chk("bp_ready_back", in_ready, 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_pending", out_valid, 32'd0);
    step();
    chk("bp_next_valid", out_valid, 32'd1);
    chk("bp_next_acc",   acc_out,   32'd16129);
    chk("bp_next_cnt",   out_cnt,   32'd1);
    chk("bp_next_sat",   out_sat,   32'd0);
    step();
    chk("bp_next_clr", out_valid, 32'd0);

    // Reset mid-vector drops the partial sum and the in-flight product.
    beat(10, 10, 1'b0);
    beat(10, 10, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_acc",   acc_out,  32'd0);
    chk("midrst_cnt",   out_cnt,  32'd0);
    chk("midrst_ready", in_ready, 32'd1);
    beat(1, 1, 1'b1);
    take("midrst", 1, 1, 1'b0);

    // Gapped input; partial sum visible during the gap.
    beat(5, 5, 1'b0);
    step(); step(); step();
    chk("gap_partial", acc_out, 32'd25);
    chk("gap_pcnt",    out_cnt, 32'd1);
    beat(6, 6, 1'b1);
    take("gap", 61, 2, 1'b0);

    // Beat counter saturates at 31.
    for (int i = 0; i < 33; i++) beat(1, 1, i == 32);
    take("cntsat", 33, 31, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
